// File: rtl/dcache_assoc_ctrl.sv
// N-way set-associative, write-back, write-allocate L1 data cache controller.
// Optional hit/miss/write-back counters are built when DCACHE_PERF_CNT_EN is defined.
//
// Ports:
//   clk_i, rst_i               clock, asynchronous active-high reset
//   cpu_addr_i, cpu_data_i     byte address and store data from EX/MEM
//   cpu_MemRead_i/MemWrite_i   load / store request (both high = store)
//   cpu_data_o                 load data, valid in the hit cycle
//   cpu_stall_o                pipeline freeze while a miss is serviced
//   mem_data_i, mem_ack_i      refill line and one-cycle completion pulse
//   mem_data_o, mem_addr_o     write-back line and line-aligned address
//   mem_enable_o, mem_write_o  request strobe, 1 = write-back, 0 = refill
//   hit_cnt_o, miss_cnt_o,
//   wb_cnt_o                   event counters (DCACHE_PERF_CNT_EN only)
module dcache_assoc_ctrl #(
    parameter int WAYS   = 2,
    parameter int SETS   = 16,
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [31:0]       cpu_data_i,
    input  logic              cpu_MemRead_i,
    input  logic              cpu_MemWrite_i,
    output logic [31:0]       cpu_data_o,
    output logic              cpu_stall_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o,
    output logic [31:0]       wb_cnt_o
`endif
);

    localparam int OFF    = $clog2(LINE_W / 8);
    localparam int WORDS  = LINE_W / 32;
    localparam int WSEL_W = $clog2(WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE,
        REFILL
    } state_t;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [WSEL_W-1:0] wsel;
    logic              unused_byte_sel;

    assign idx  = cpu_addr_i[OFF +: IDX_W];
    assign tag  = cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign wsel = cpu_addr_i[2 +: WSEL_W];
    assign unused_byte_sel = ^cpu_addr_i[1:0];

    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   dirty_q [SETS];
    logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
    logic [LINE_W-1:0] line_q  [WAYS][SETS];

    state_t            state_q;
    logic [WAY_W-1:0]  vic_q;
    logic [IDX_W-1:0]  miss_idx_q;
    logic [TAG_W-1:0]  miss_tag_q;
    logic [LINE_W-1:0] fill_q;

    logic              req;
    logic              is_wr;
    logic              hit;
    logic              hit_acc;
    logic              miss;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  lru_way;
    logic [WAY_W-1:0]  victim;
    logic [LINE_W-1:0] hit_line;
    logic [31:0]       rd_word;

    assign req   = cpu_MemRead_i | cpu_MemWrite_i;
    assign is_wr = cpu_MemWrite_i;

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && (tag_q[w][idx] == tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    assign hit_line = line_q[hit_way][idx];

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (wsel == WSEL_W'(i)) rd_word = hit_line[i*32 +: 32];
        end
    end

    // Descending scan so the lowest-indexed invalid way wins.
    always_comb begin
        victim = lru_way;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[idx][w]) victim = WAY_W'(w);
        end
    end

    assign hit_acc = (state_q == IDLE) && req && hit;
    assign miss    = (state_q == IDLE) && req && !hit;

    assign cpu_stall_o = !rst_i && ((state_q != IDLE) || (req && !hit));
    assign cpu_data_o  = (!rst_i && hit_acc && !is_wr) ? rd_word : '0;

    if (WAYS > 1) begin : g_lru
        localparam logic [WAY_W-1:0] AGE_MAX = WAY_W'(WAYS - 1);

        logic [WAY_W-1:0] age_q [SETS][WAYS];
        logic [WAY_W-1:0] hit_age;

        assign hit_age = age_q[idx][hit_way];

        always_comb begin
            lru_way = '0;
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[idx][w] == AGE_MAX) lru_way = WAY_W'(w);
            end
        end

        // Equal ages only exist after reset; ageing ties as well as
        // younger ways spreads them into a distinct ordering as the
        // set fills, so exactly one way reaches AGE_MAX once full.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                for (int s = 0; s < SETS; s++) begin
                    for (int w = 0; w < WAYS; w++) age_q[s][w] <= '0;
                end
            end else if (hit_acc) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == hit_way) begin
                        age_q[idx][w] <= '0;
                    end else if ((age_q[idx][w] <= hit_age) &&
                                 (age_q[idx][w] != AGE_MAX)) begin
                        age_q[idx][w] <= age_q[idx][w] + 1'b1;
                    end
                end
            end
        end
    end else begin : g_dm
        assign lru_way = '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            vic_q        <= '0;
            miss_idx_q   <= '0;
            miss_tag_q   <= '0;
            fill_q       <= '0;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (miss) begin
                        vic_q        <= victim;
                        miss_idx_q   <= idx;
                        miss_tag_q   <= tag;
                        mem_enable_o <= 1'b1;
                        if (valid_q[idx][victim] && dirty_q[idx][victim]) begin
                            state_q     <= WRITEBACK;
                            mem_write_o <= 1'b1;
                            mem_addr_o  <= {tag_q[victim][idx], idx,
                                            {OFF{1'b0}}};
                            mem_data_o  <= line_q[victim][idx];
                        end else begin
                            state_q     <= ALLOCATE;
                            mem_write_o <= 1'b0;
                            mem_addr_o  <= {tag, idx, {OFF{1'b0}}};
                        end
                    end else if (hit_acc && is_wr) begin
                        dirty_q[idx][hit_way] <= 1'b1;
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        state_q     <= ALLOCATE;
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= {miss_tag_q, miss_idx_q, {OFF{1'b0}}};
                    end
                end
                ALLOCATE: begin
                    if (mem_ack_i) begin
                        fill_q       <= mem_data_i;
                        mem_enable_o <= 1'b0;
                        state_q      <= REFILL;
                    end
                end
                REFILL: begin
                    valid_q[miss_idx_q][vic_q] <= 1'b1;
                    dirty_q[miss_idx_q][vic_q] <= 1'b0;
                    state_q                    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Line data and tags survive reset; valid bits alone gate their use.
    always_ff @(posedge clk_i) begin
        if (state_q == REFILL) begin
            line_q[vic_q][miss_idx_q] <= fill_q;
            tag_q[vic_q][miss_idx_q]  <= miss_tag_q;
        end else if (hit_acc && is_wr) begin
            for (int i = 0; i < WORDS; i++) begin
                if (wsel == WSEL_W'(i)) begin
                    line_q[hit_way][idx][i*32 +: 32] <= cpu_data_i;
                end
            end
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
            wb_cnt_o   <= '0;
        end else begin
            if (hit_acc) hit_cnt_o <= hit_cnt_o + 32'd1;
            if (miss) miss_cnt_o <= miss_cnt_o + 32'd1;
            if ((state_q == WRITEBACK) && mem_ack_i) wb_cnt_o <= wb_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_assoc_ctrl.sv
// Randomised scoreboard bench for dcache_assoc_ctrl (WAYS=2, SETS=16).
// Reference model: per-set ways with timestamps for LRU, plus a backing-memory map.
module tb_dcache_assoc_ctrl;

    localparam int WAYS   = 2;
    localparam int SETS   = 16;
    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;
    localparam int LMEM   = 10;
    localparam int TOUT   = 200;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic [ADDR_W-1:0] cpu_addr_i = '0;
    logic [31:0]       cpu_data_i = '0;
    logic              cpu_MemRead_i = 1'b0;
    logic              cpu_MemWrite_i = 1'b0;
    logic [31:0]       cpu_data_o;
    logic              cpu_stall_o;
    logic [LINE_W-1:0] mem_data_i = '0;
    logic              mem_ack_i = 1'b0;
    logic [LINE_W-1:0] mem_data_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_enable_o;
    logic              mem_write_o;

    always #5 clk_i = ~clk_i;

    dcache_assoc_ctrl #(
        .WAYS(WAYS), .SETS(SETS), .LINE_W(LINE_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .cpu_addr_i(cpu_addr_i),
        .cpu_data_i(cpu_data_i),
        .cpu_MemRead_i(cpu_MemRead_i),
        .cpu_MemWrite_i(cpu_MemWrite_i),
        .cpu_data_o(cpu_data_o),
        .cpu_stall_o(cpu_stall_o),
        .mem_data_i(mem_data_i),
        .mem_ack_i(mem_ack_i),
        .mem_data_o(mem_data_o),
        .mem_addr_o(mem_addr_o),
        .mem_enable_o(mem_enable_o),
        .mem_write_o(mem_write_o)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [255:0] data;
    } mexp_t;

    typedef struct {
        bit          rd;
        logic [31:0] data;
        int          stall;
    } cexp_t;

    mexp_t mq[$];
    cexp_t cq[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    logic [255:0] dram [int];

    bit           m_val   [SETS][WAYS];
    bit           m_dirty [SETS][WAYS];
    logic [31:0]  m_tag   [SETS][WAYS];
    logic [255:0] m_line  [SETS][WAYS];
    longint       m_stamp [SETS][WAYS];
    longint       tick = 0;

    function automatic logic [255:0] dram_get(input logic [31:0] la);
        logic [255:0] l;
        if (dram.exists(int'(la))) return dram[int'(la)];
        for (int w = 0; w < 8; w++)
            l[w*32 +: 32] = (la * 32'h9E37_79B1) ^ (32'(w) << 24) ^ 32'h5A5A_0000;
        return l;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_val[s][w]   = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_stamp[s][w] = 0;
            end
    endtask

    // Applies one access; pushes expected memory traffic, returns the
    // number of stalled cycles and the load data.
    task automatic model_access(input logic [31:0] a, input bit is_wr,
                                input logic [31:0] d, output int st,
                                output logic [31:0] rdat);
        int s, w, way;
        logic [31:0] t;
        mexp_t m;
        s = int'((a >> 5) % SETS);
        t = a >> 9;
        w = int'((a >> 2) & 7);
        way = -1;
        rdat = '0;
        for (int i = 0; i < WAYS; i++)
            if (m_val[s][i] && m_tag[s][i] == t) way = i;
        if (way < 0) begin
            for (int i = WAYS - 1; i >= 0; i--)
                if (!m_val[s][i]) way = i;
            if (way < 0) begin
                way = 0;
                for (int i = 1; i < WAYS; i++)
                    if (m_stamp[s][i] < m_stamp[s][way]) way = i;
            end
            // Stall spans the miss cycle through REFILL, so release falls on
            // cycle Lmem+3 (clean) or 2*Lmem+3 (dirty) counting the miss as 1.
            if (m_val[s][way] && m_dirty[s][way]) begin
                m.wr = 1'b1;
                m.addr = (m_tag[s][way] << 9) | (32'(s) << 5);
                m.data = m_line[s][way];
                mq.push_back(m);
                dram[int'(m.addr)] = m_line[s][way];
                st = 2 * LMEM + 2;
            end else begin
                st = LMEM + 2;
            end
            m.wr = 1'b0;
            m.addr = a & ~32'h1F;
            m.data = '0;
            mq.push_back(m);
            m_line[s][way]  = dram_get(a & ~32'h1F);
            m_val[s][way]   = 1'b1;
            m_dirty[s][way] = 1'b0;
            m_tag[s][way]   = t;
        end else begin
            st = 0;
        end
        tick++;
        m_stamp[s][way] = tick;
        if (is_wr) begin
            m_line[s][way][w*32 +: 32] = d;
            m_dirty[s][way] = 1'b1;
        end else begin
            rdat = m_line[s][way][w*32 +: 32];
        end
    endtask

    // ---------------- memory responder + request checker ----------------
    int    cnt = 0;
    int    inj_req = 0;
    int    inj_done = 0;
    mexp_t cur;

    always @(negedge clk_i) begin
        if (mem_ack_i) begin
            mem_ack_i = 1'b0;
            cnt = 0;
        end
        if (rst_i) begin
            cnt = 0;
        end else if (inj_req != inj_done) begin
            inj_done++;
            mem_ack_i = 1'b1;
        end else if (mem_enable_o) begin
            cnt++;
            if (cnt == 1) begin
                chk("mem_req_expected", 256'(mq.size() != 0), 256'(1));
                if (mq.size() != 0) begin
                    cur = mq.pop_front();
                    chk("mem_write", 256'(mem_write_o), 256'(cur.wr));
                    chk("mem_addr", 256'(mem_addr_o), 256'(cur.addr));
                    if (cur.wr) chk("wb_line", mem_data_o, cur.data);
                end
            end
            if (cnt == LMEM) begin
                chk("mem_addr_hold", 256'(mem_addr_o), 256'(cur.addr));
                if (cur.wr) chk("wb_line_hold", mem_data_o, cur.data);
                else mem_data_i = dram_get(mem_addr_o);
                mem_ack_i = 1'b1;
            end
        end else begin
            cnt = 0;
        end
    end

    // ---------------- CPU-side monitor ----------------
    int    scnt = 0;
    cexp_t c;

    always @(negedge clk_i) begin
        if (rst_i || !(cpu_MemRead_i || cpu_MemWrite_i)) begin
            scnt = 0;
        end else if (cpu_stall_o) begin
            scnt++;
        end else begin
            chk("cpu_resp_expected", 256'(cq.size() != 0), 256'(1));
            if (cq.size() != 0) begin
                c = cq.pop_front();
                chk("stall_cycles", 256'(scnt), 256'(c.stall));
                if (c.rd) chk("load_data", 256'(cpu_data_o), 256'(c.data));
            end
            scnt = 0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic finish_fatal(input string why);
        n_checks++;
        $display("FAIL %s: got timeout expected completion", why);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "bench stopped");
    endtask

    task automatic do_access(input logic [31:0] a, input bit r, input bit w,
                             input logic [31:0] d);
        int st;
        logic [31:0] rd;
        cexp_t e;
        int n;
        model_access(a, w, d, st, rd);
        e.rd = r && !w;
        e.data = rd;
        e.stall = st;
        cq.push_back(e);
        cpu_addr_i = a;
        cpu_data_i = d;
        cpu_MemRead_i = r;
        cpu_MemWrite_i = w;
        for (n = 0; n < TOUT; n++) begin
            @(negedge clk_i);
            if (!cpu_stall_o) break;
        end
        if (n == TOUT) finish_fatal("access_timeout");
        @(posedge clk_i);
        #1;
        cpu_MemRead_i = 1'b0;
        cpu_MemWrite_i = 1'b0;
    endtask

    task automatic chk_zero_outs(input string tag);
        chk({tag, "_stall"}, 256'(cpu_stall_o), 256'(0));
        chk({tag, "_cpu_data"}, 256'(cpu_data_o), 256'(0));
        chk({tag, "_mem_en"}, 256'(mem_enable_o), 256'(0));
        chk({tag, "_mem_wr"}, 256'(mem_write_o), 256'(0));
        chk({tag, "_mem_addr"}, 256'(mem_addr_o), 256'(0));
        chk({tag, "_mem_data"}, mem_data_o, 256'(0));
    endtask

    initial begin
        logic [255:0] l;
        logic [31:0]  a;
        int st, n, k;
        logic [31:0] rd;

        model_reset();
        idle(2);
        chk_zero_outs("reset");
        rst_i = 1'b0;
        idle(1);

        l = dram_get(32'h40);
        l[2*32 +: 32] = 32'hDEAD_BEEF;
        dram[32'h40] = l;

        // cold miss then hit
        do_access(32'h40, 1, 0, 0);
        do_access(32'h40, 1, 0, 0);
        // write hit, then two conflicting fills force a dirty eviction
        do_access(32'h44, 0, 1, 32'h1234_5678);
        do_access(32'h244, 1, 0, 0);
        do_access(32'h444, 1, 0, 0);
        // LRU victim choice among clean lines
        do_access(32'h40, 1, 0, 0);
        do_access(32'h240, 1, 0, 0);
        do_access(32'h40, 1, 0, 0);
        do_access(32'h440, 1, 0, 0);
        // read and write together behave as a store
        do_access(32'h80, 1, 1, 32'hA5A5_A5A5);
        do_access(32'h80, 1, 0, 0);

        // reset in the middle of a refill, stray ack afterwards
        a = 32'hC0;
        model_access(a, 0, 0, st, rd);
        cpu_addr_i = a;
        cpu_MemRead_i = 1'b1;
        for (n = 0; n < 50; n++) begin
            @(negedge clk_i);
            if (mem_enable_o && !mem_write_o) break;
        end
        chk("abort_alloc_seen", 256'(n < 50), 256'(1));
        repeat (3) @(negedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        cpu_MemRead_i = 1'b0;
        #1;
        chk_zero_outs("midmiss_rst");
        model_reset();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        inj_req++;
        repeat (3) @(negedge clk_i);
        chk("stray_ack_en", 256'(mem_enable_o), 256'(0));
        chk("stray_ack_stall", 256'(cpu_stall_o), 256'(0));
        idle(1);
        do_access(32'h40, 1, 0, 0);
        do_access(32'hC0, 1, 0, 0);

        // randomised traffic over 4 tags x 4 sets
        for (int i = 0; i < 400; i++) begin
            a = (32'($urandom_range(0, 3)) << 9) |
                (32'($urandom_range(0, 3)) << 5) |
                32'($urandom_range(0, 31));
            k = $urandom_range(0, 2);
            do_access(a, k != 1, k != 0, $urandom);
            idle($urandom_range(0, 2));
        end

        idle(5);
        chk("mem_queue_drained", 256'(mq.size()), 256'(0));
        chk("cpu_queue_drained", 256'(cq.size()), 256'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
